// File: rtl/rtype_execute_controller_pkg.sv
// Shared RV64 R-type execute definitions: encodings, sequencer states, ALU ops.
// The decoder folds every unsupported encoding into OP_ILL.
package rv64_exec_defs;

  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SRL  = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  typedef enum logic [2:0] {ST_IDLE, ST_READ, ST_EXEC, ST_WRITE, ST_ILL} state_e;

  typedef enum logic [3:0] {
    OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR,
    OP_SRL, OP_SRA, OP_OR, OP_AND, OP_MUL, OP_ILL
  } alu_op_e;

  function automatic alu_op_e decode_op(input logic [31:0] instr);
    alu_op_e op;
    op = OP_ILL;
    if (instr[6:0] == OPC_OP) begin
      case (instr[31:25])
        F7_BASE: begin
          case (instr[14:12])
            F3_ADD:  op = OP_ADD;
            F3_SLL:  op = OP_SLL;
            F3_SLT:  op = OP_SLT;
            F3_SLTU: op = OP_SLTU;
            F3_XOR:  op = OP_XOR;
            F3_SRL:  op = OP_SRL;
            F3_OR:   op = OP_OR;
            default: op = OP_AND;
          endcase
        end
        F7_ALT: begin
          if (instr[14:12] == F3_ADD)      op = OP_SUB;
          else if (instr[14:12] == F3_SRL) op = OP_SRA;
        end
        F7_MULDIV: if (instr[14:12] == F3_ADD) op = OP_MUL;
        default: op = OP_ILL;
      endcase
    end
    return op;
  endfunction

endpackage

// File: rtl/rtype_execute_controller_if.sv
// Instruction handshake plus register-file port bundle for the execute sequencer.
interface rtype_execute_controller_if #(parameter int DATA_W = 64);
  logic              instr_valid;
  logic [31:0]       instr;
  logic              instr_ready;
  logic              rf_E;
  logic [4:0]        rf_read_register1;
  logic [4:0]        rf_read_register2;
  logic [4:0]        rf_write_register;
  logic [DATA_W-1:0] rf_write_data;
  logic              rf_register_write;
  logic [DATA_W-1:0] rf_read_data1;
  logic [DATA_W-1:0] rf_read_data2;
  logic              busy;
  logic              done;
  logic              illegal;

  modport master (
    input  instr_valid, instr, rf_read_data1, rf_read_data2,
    output instr_ready, rf_E, rf_read_register1, rf_read_register2,
           rf_write_register, rf_write_data, rf_register_write,
           busy, done, illegal
  );

  modport slave (
    output instr_valid, instr, rf_read_data1, rf_read_data2,
    input  instr_ready, rf_E, rf_read_register1, rf_read_register2,
           rf_write_register, rf_write_data, rf_register_write,
           busy, done, illegal
  );
endinterface

// File: rtl/rtype_execute_controller_mul.sv
// Iterative shift-add multiplier, one partial product per cycle.
// done is high during the final iteration; product is valid the cycle after.
module mul_64_iterative #(
  parameter int DATA_W   = 64,
  parameter int MUL_ITER = DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              done,
  output logic [DATA_W-1:0] product
);

  logic              active_q, active_d;
  logic [DATA_W-1:0] mcand_q, mcand_d, mplier_q, mplier_d, acc_q, acc_d;
  logic [6:0]        cnt_q, cnt_d;

  assign done    = active_q && (cnt_q == 7'(MUL_ITER - 1));
  assign product = acc_q;

  always_comb begin
    active_d = active_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    if (start) begin
      active_d = 1'b1;
      mcand_d  = a;
      mplier_d = b;
      acc_d    = '0;
      cnt_d    = '0;
    end else if (active_q) begin
      if (mplier_q[0]) acc_d = acc_q + mcand_q;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + 7'd1;
      if (done) active_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      active_q <= 1'b0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else begin
      active_q <= active_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/rtype_execute_controller.sv
// RV64 R-type execute sequencer: IDLE -> READ -> EXEC -> WRITE (or ILL) -> IDLE,
// feeding and writing back a 32x64 register file.
module rtype_execute_controller
  import rv64_exec_defs::*;
#(
  parameter int DATA_W   = 64,
  parameter int MUL_ITER = DATA_W
) (
  input  logic                          clk,
  input  logic                          rst_n,
  rtype_execute_controller_if.master    bus
);

  localparam int SH_W = $clog2(DATA_W);

  state_e            state_q, state_d;
  logic [31:0]       instr_q, instr_d;
  logic [DATA_W-1:0] op_a_q, op_a_d, op_b_q, op_b_d, result_q, result_d;
  logic [DATA_W-1:0] alu_res, mul_product;
  logic [SH_W-1:0]   shamt;
  logic              mul_start, mul_done;
  alu_op_e           op;

  assign op    = decode_op(instr_q);
  assign shamt = op_b_q[SH_W-1:0];

  always_comb begin
    alu_res = '0;
    case (op)
      OP_ADD:  alu_res = op_a_q + op_b_q;
      OP_SUB:  alu_res = op_a_q - op_b_q;
      OP_SLL:  alu_res = op_a_q << shamt;
      OP_SLT:  alu_res = {{(DATA_W-1){1'b0}}, $signed(op_a_q) < $signed(op_b_q)};
      OP_SLTU: alu_res = {{(DATA_W-1){1'b0}}, op_a_q < op_b_q};
      OP_XOR:  alu_res = op_a_q ^ op_b_q;
      OP_SRL:  alu_res = op_a_q >> shamt;
      OP_SRA:  alu_res = $signed(op_a_q) >>> shamt;
      OP_OR:   alu_res = op_a_q | op_b_q;
      OP_AND:  alu_res = op_a_q & op_b_q;
      default: alu_res = '0;
    endcase
  end

  mul_64_iterative #(.DATA_W(DATA_W), .MUL_ITER(MUL_ITER)) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (mul_start),
    .a       (bus.rf_read_data1),
    .b       (bus.rf_read_data2),
    .done    (mul_done),
    .product (mul_product)
  );

  always_comb begin
    state_d   = state_q;
    instr_d   = instr_q;
    op_a_d    = op_a_q;
    op_b_d    = op_b_q;
    result_d  = result_q;
    mul_start = 1'b0;
    case (state_q)
      ST_IDLE: if (bus.instr_valid) begin
        instr_d = bus.instr;
        state_d = ST_READ;
      end
      ST_READ: begin
        op_a_d = bus.rf_read_data1;
        op_b_d = bus.rf_read_data2;
        if (op == OP_ILL) begin
          state_d = ST_ILL;
        end else begin
          state_d   = ST_EXEC;
          mul_start = (op == OP_MUL);
        end
      end
      ST_EXEC: begin
        if (op != OP_MUL) begin
          result_d = alu_res;
          state_d  = ST_WRITE;
        end else if (mul_done) begin
          state_d = ST_WRITE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      instr_q  <= '0;
      op_a_q   <= '0;
      op_b_q   <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      instr_q  <= instr_d;
      op_a_q   <= op_a_d;
      op_b_q   <= op_b_d;
      result_q <= result_d;
    end
  end

  // Addresses come straight from the latched word, so they hold through WRITE.
  assign bus.rf_read_register1 = instr_q[19:15];
  assign bus.rf_read_register2 = instr_q[24:20];
  assign bus.rf_write_register = instr_q[11:7];
  assign bus.instr_ready       = (state_q == ST_IDLE);
  assign bus.busy              = (state_q != ST_IDLE);
  assign bus.rf_E              = (state_q == ST_WRITE);
  assign bus.rf_register_write = (state_q == ST_WRITE) && (instr_q[11:7] != 5'd0);
  assign bus.done              = (state_q == ST_WRITE) || (state_q == ST_ILL);
  assign bus.illegal           = (state_q == ST_ILL);
  assign bus.rf_write_data     = (state_q != ST_WRITE) ? '0 :
                                 (op == OP_MUL)        ? mul_product : result_q;

endmodule

// File: tb/tb_rtype_execute_controller.sv
// Directed bench: behavioural register file, vector table, reset-mid-MUL sequence.
module tb_rtype_execute_controller;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rtype_execute_controller_if #(.DATA_W(64)) ifc ();

  rtype_execute_controller #(.DATA_W(64), .MUL_ITER(64)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc.master)
  );

  // Behavioural register file; pokes preload it while the DUT is idle.
  logic [63:0] regs [32];
  logic        poke_en = 1'b0;
  logic [4:0]  poke_addr = '0;
  logic [63:0] poke_data = '0;

  always @(posedge clk) begin
    if (poke_en) regs[poke_addr] <= poke_data;
    else if (ifc.rf_E && ifc.rf_register_write) regs[ifc.rf_write_register] <= ifc.rf_write_data;
  end

  assign ifc.rf_read_data1 = (ifc.rf_read_register1 == 5'd0) ? 64'd0 : regs[ifc.rf_read_register1];
  assign ifc.rf_read_data2 = (ifc.rf_read_register2 == 5'd0) ? 64'd0 : regs[ifc.rf_read_register2];

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] instr;
    logic [63:0] x1;
    logic [63:0] x2;
    logic [4:0]  rd;
    logic [63:0] data;
    int          done_cyc;
    logic        ill;
    logic        we;
    logic        hold;
  } vec_t;

  vec_t vecs [18];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic poke(input logic [4:0] a, input logic [63:0] d);
    @(negedge clk);
    poke_en = 1'b1; poke_addr = a; poke_data = d;
    @(negedge clk);
    poke_en = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int done_at, strobes;
    logic ill_seen;
    logic [63:0] wdata;
    done_at = -1; strobes = 0; ill_seen = 1'b0; wdata = '0;
    poke(5'd1, v.x1);
    poke(5'd2, v.x2);
    @(negedge clk);
    check($sformatf("v%0d ready_before", idx), {63'd0, ifc.instr_ready}, 64'd1);
    ifc.instr_valid = 1'b1;
    ifc.instr       = v.instr;
    @(posedge clk);
    #1;
    if (v.hold) ifc.instr = 32'h40208233;  // keep offering while busy; must be ignored
    else ifc.instr_valid = 1'b0;
    for (int cyc = 1; cyc <= 100 && done_at < 0; cyc++) begin
      @(negedge clk);
      if (cyc == 1) check($sformatf("v%0d busy_c1", idx), {63'd0, ifc.busy}, 64'd1);
      if (ifc.rf_register_write) strobes++;
      if (ifc.done) begin
        done_at  = cyc;
        ill_seen = ifc.illegal;
        wdata    = ifc.rf_write_data;
      end
    end
    ifc.instr_valid = 1'b0;
    check($sformatf("v%0d done_cycle", idx), 64'(done_at), 64'(v.done_cyc));
    check($sformatf("v%0d illegal", idx), {63'd0, ill_seen}, {63'd0, v.ill});
    check($sformatf("v%0d strobes", idx), 64'(strobes), v.we ? 64'd1 : 64'd0);
    if (!v.ill) check($sformatf("v%0d wdata", idx), wdata, v.data);
    @(negedge clk);
    check($sformatf("v%0d ready_after", idx), {63'd0, ifc.instr_ready}, 64'd1);
    check($sformatf("v%0d busy_after", idx), {63'd0, ifc.busy}, 64'd0);
    check($sformatf("v%0d we_after", idx), {63'd0, ifc.rf_register_write}, 64'd0);
    if (v.we) begin
      check($sformatf("v%0d wreg", idx), 64'(ifc.rf_write_register), 64'(v.rd));
      check($sformatf("v%0d regfile", idx), regs[v.rd], v.data);
    end
  endtask

  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  initial begin
    int strobes, dones;
    vecs[0]  = '{32'h002081B3, 64'd5, 64'd3,    5'd3,  64'd8, 3, 1'b0, 1'b1, 1'b1};
    vecs[1]  = '{32'h40208233, 64'd5, 64'd3,    5'd4,  64'd2, 3, 1'b0, 1'b1, 1'b0};
    vecs[2]  = '{32'h40208233, 64'd3, 64'd5,    5'd4,  64'hFFFF_FFFF_FFFF_FFFE, 3, 1'b0, 1'b1, 1'b0};
    vecs[3]  = '{32'h022082B3, 64'd5, 64'd3,    5'd5,  64'd15, 66, 1'b0, 1'b1, 1'b0};
    vecs[4]  = '{32'h022082B3, ONES,  ONES,     5'd5,  64'd1, 66, 1'b0, 1'b1, 1'b0};
    vecs[5]  = '{32'h4023D333, 64'd5, 64'd3,    5'd6,  64'hF000_0000_0000_0000, 3, 1'b0, 1'b1, 1'b0};
    vecs[6]  = '{32'h0023D333, 64'd5, 64'd3,    5'd6,  64'h1000_0000_0000_0000, 3, 1'b0, 1'b1, 1'b0};
    vecs[7]  = '{32'h00208033, 64'd5, 64'd3,    5'd0,  64'd8, 3, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{32'h00000013, 64'd5, 64'd3,    5'd0,  64'd0, 2, 1'b1, 1'b0, 1'b0};
    vecs[9]  = '{32'h0020A433, ONES,  64'd3,    5'd8,  64'd1, 3, 1'b0, 1'b1, 1'b0};
    vecs[10] = '{32'h0020B433, ONES,  64'd3,    5'd8,  64'd0, 3, 1'b0, 1'b1, 1'b0};
    vecs[11] = '{32'h0020C4B3, 64'd5, 64'd3,    5'd9,  64'd6, 3, 1'b0, 1'b1, 1'b0};
    vecs[12] = '{32'h0020E533, 64'd5, 64'd3,    5'd10, 64'd7, 3, 1'b0, 1'b1, 1'b0};
    vecs[13] = '{32'h0020F5B3, 64'd5, 64'd3,    5'd11, 64'd1, 3, 1'b0, 1'b1, 1'b0};
    vecs[14] = '{32'h00209633, 64'd5, 64'h41,   5'd12, 64'd10, 3, 1'b0, 1'b1, 1'b0};
    vecs[15] = '{32'h022092B3, 64'd5, 64'd3,    5'd5,  64'd0, 2, 1'b1, 1'b0, 1'b0};
    vecs[16] = '{32'h402092B3, 64'd5, 64'd3,    5'd5,  64'd0, 2, 1'b1, 1'b0, 1'b0};
    vecs[17] = '{32'h4023D333, 64'd5, 64'h3F,   5'd6,  ONES, 3, 1'b0, 1'b1, 1'b0};

    ifc.instr_valid = 1'b0;
    ifc.instr       = '0;
    for (int r = 0; r < 32; r++) poke(5'(r), 64'd0);
    poke(5'd7, 64'h8000_0000_0000_0000);

    @(negedge clk);
    check("rst ready",  {63'd0, ifc.instr_ready}, 64'd1);
    check("rst busy",   {63'd0, ifc.busy}, 64'd0);
    check("rst done",   {63'd0, ifc.done}, 64'd0);
    check("rst illegal",{63'd0, ifc.illegal}, 64'd0);
    check("rst rf_E",   {63'd0, ifc.rf_E}, 64'd0);
    check("rst we",     {63'd0, ifc.rf_register_write}, 64'd0);
    check("rst wdata",  ifc.rf_write_data, 64'd0);
    check("rst addrs",  64'({ifc.rf_read_register1, ifc.rf_read_register2, ifc.rf_write_register}), 64'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 18; i++) run_vec(vecs[i], i);

    // Reset in the middle of a MUL: nothing may ever be written.
    poke(5'd5, 64'hDEAD);
    poke(5'd1, 64'd5);
    poke(5'd2, 64'd3);
    @(negedge clk);
    ifc.instr_valid = 1'b1;
    ifc.instr       = 32'h022082B3;
    @(posedge clk);
    #1 ifc.instr_valid = 1'b0;
    strobes = 0; dones = 0;
    for (int cyc = 1; cyc <= 30; cyc++) begin
      @(negedge clk);
      if (ifc.rf_register_write) strobes++;
      if (ifc.done) dones++;
    end
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst busy",  {63'd0, ifc.busy}, 64'd0);
    check("midrst ready", {63'd0, ifc.instr_ready}, 64'd1);
    check("midrst we",    {63'd0, ifc.rf_register_write}, 64'd0);
    check("midrst wdata", ifc.rf_write_data, 64'd0);
    rst_n = 1'b1;
    for (int cyc = 0; cyc < 80; cyc++) begin
      @(negedge clk);
      if (ifc.rf_register_write) strobes++;
      if (ifc.done) dones++;
    end
    check("midrst strobes", 64'(strobes), 64'd0);
    check("midrst dones",   64'(dones), 64'd0);
    check("midrst x5",      regs[5], 64'hDEAD);
    run_vec(vecs[1], 100);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
